// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic RAM slave: 32-bit data words plus one tag per word, with word/half/byte/tag lanes.
// ACK_O pulses for one cycle in cycle WAIT_STATES+1 after the request is sampled; the slave has no stall, so each access takes WAIT_STATES+2 cycles.
module wb_ram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1,
  parameter int TAG_WIDTH   = 4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  req;
  logic                  lat_we;
  logic [ADDR_WIDTH+1:0] lat_adr;
  logic [31:0]           lat_dat;
  logic [3:0]            lat_sel;

  logic                  acc_live, access;
  logic                  acc_we;
  logic [ADDR_WIDTH+1:0] acc_adr;
  logic [31:0]           acc_dat;
  logic [3:0]            acc_sel;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           wdat, rd_word, rdat;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic                  tag_wr;

  logic [31:0]           mem     [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_mem [DEPTH];

  logic unused_adr;
  assign unused_adr = ^ADR_I[31:ADDR_WIDTH+2];

  assign req = CYC_I & STB_I;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ACK_O     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACK;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACK: begin
        ACK_O     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (state == IDLE && req) begin
      lat_we  <= WE_I;
      lat_adr <= ADR_I[ADDR_WIDTH+1:0];
      lat_dat <= DAT_I;
      lat_sel <= SEL_I;
    end
  end

  // With zero wait states the access happens on the sampling edge, so the live bus is used directly.
  assign acc_live = (state == IDLE);
  assign acc_we   = acc_live ? WE_I                  : lat_we;
  assign acc_adr  = acc_live ? ADR_I[ADDR_WIDTH+1:0] : lat_adr;
  assign acc_dat  = acc_live ? DAT_I                 : lat_dat;
  assign acc_sel  = acc_live ? SEL_I                 : lat_sel;
  assign access   = RST_I && (state != ACK) && (state_nxt == ACK);
  assign idx      = acc_adr[ADDR_WIDTH+1:2];
  assign rd_word  = mem[idx];
  assign rd_tag   = tag_mem[idx];

  always_comb begin
    be     = 4'b0000;
    wdat   = acc_dat;
    rdat   = 32'h0;
    tag_wr = 1'b0;
    case (acc_sel)
      4'b1111: begin
        be   = 4'b1111;
        rdat = rd_word;
      end
      4'b0011: begin
        be   = acc_adr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{acc_dat[15:0]}};
        rdat = {16'h0, acc_adr[1] ? rd_word[31:16] : rd_word[15:0]};
      end
      4'b0001: begin
        be   = 4'b0001 << acc_adr[1:0];
        wdat = {4{acc_dat[7:0]}};
        case (acc_adr[1:0])
          2'd0:    rdat = {24'h0, rd_word[7:0]};
          2'd1:    rdat = {24'h0, rd_word[15:8]};
          2'd2:    rdat = {24'h0, rd_word[23:16]};
          default: rdat = {24'h0, rd_word[31:24]};
        endcase
      end
      4'b0101: begin
        tag_wr = 1'b1;
        rdat   = {{(32-TAG_WIDTH){1'b0}}, rd_tag};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (access && acc_we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdat[8*k +: 8];
      end
      if (tag_wr) tag_mem[idx] <= acc_dat[TAG_WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I)      DAT_O <= 32'h0;
    else if (access) DAT_O <= acc_we ? 32'h0 : rdat;
  end

endmodule
